// File: rtl/ram2port_paged_pkg.sv
// Shared constants for the paged line buffer of the line doubler.
// Holds the default page geometry, the colour format and a width helper.
package ram2port_paged_pkg;

  localparam int BUF_NUM_OF_PAGES   = 4;
  localparam int BUF_DEPTH_PER_PAGE = 800;
  localparam int COLOR_WIDTH        = 7;
  localparam int NUM_COLORS         = 3;

  // Bits needed to index 'value' entries, never less than one.
  function automatic int clog2(input int value);
    int w;
    w = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/ram2port_paged.sv
// Simple dual-port paged RAM: one write port, one read port with a fixed
// 2-cycle read latency (index register, then registered array output).
module ram2port_paged
  import ram2port_paged_pkg::*;
#(
  parameter int num_of_pages = BUF_NUM_OF_PAGES,
  parameter int pagesize     = BUF_DEPTH_PER_PAGE,
  parameter int data_width   = NUM_COLORS * COLOR_WIDTH,
  localparam int PW          = clog2(num_of_pages),
  localparam int AW          = clog2(pagesize)
) (
  input  logic                  VCLK,
  input  logic                  RST,
  input  logic                  wren,
  input  logic [PW-1:0]         wrpage,
  input  logic [AW-1:0]         wraddr,
  input  logic [data_width-1:0] wrdata,
  input  logic                  rden,
  input  logic [PW-1:0]         rdpage,
  input  logic [AW-1:0]         rdaddr,
  output logic [data_width-1:0] rddata
);

  localparam int DEPTH = num_of_pages * pagesize;
  localparam int IW    = clog2(DEPTH);

  function automatic logic [IW-1:0] flat_index(input logic [PW-1:0] page,
                                               input logic [AW-1:0] addr);
    return IW'(int'(page) * pagesize + int'(addr));
  endfunction

  // Power-up contents are zero; the array itself is never reset.
  logic [data_width-1:0] mem [DEPTH] = '{default: '0};

  logic          wr_ok;
  logic          rd_in_range;
  logic [IW-1:0] wr_idx;
  logic [IW-1:0] rd_idx;

  logic          rd_en_q;
  logic          rd_vld_q;
  logic [IW-1:0] rd_idx_q;

  assign wr_ok       = wren && (32'(wrpage) < num_of_pages) && (32'(wraddr) < pagesize);
  assign rd_in_range = (32'(rdpage) < num_of_pages) && (32'(rdaddr) < pagesize);
  assign wr_idx      = flat_index(wrpage, wraddr);
  assign rd_idx      = flat_index(rdpage, rdaddr);

  // NOTE: the array gets no reset branch -- a reset loop over every word
  // would stop the tools from mapping it onto block RAM.
  always_ff @(posedge VCLK) begin
    if (!RST && wr_ok) mem[wr_idx] <= wrdata;
  end

  // Stage 1: capture the read request.
  always_ff @(posedge VCLK) begin
    if (RST) begin
      rd_en_q  <= 1'b0;
      rd_vld_q <= 1'b0;
      rd_idx_q <= '0;
    end else begin
      rd_en_q <= rden;
      if (rden) begin
        rd_idx_q <= rd_idx;
        rd_vld_q <= rd_in_range;
      end
    end
  end

  // Stage 2: registered array output. Out-of-range reads use the output
  // register's synchronous clear so the RAM read path stays a plain lookup.
  // NOTE: non-blocking assignment here and in the write port is what makes a
  // same-edge read of the word being written return the old contents.
  always_ff @(posedge VCLK) begin
    if (RST || (rd_en_q && !rd_vld_q)) begin
      rddata <= '0;
    end else if (rd_en_q) begin
      rddata <= mem[rd_idx_q];
    end
  end

endmodule

// File: tb/tb_ram2port_paged.sv
// Randomised scoreboard bench for ram2port_paged: a page/word array model
// predicts rddata per edge; a negedge monitor pops and compares.
module tb_ram2port_paged;

  localparam int NP = 4;
  localparam int PS = 800;
  localparam int DW = 21;
  localparam int PW = 2;
  localparam int AW = 10;

  logic          VCLK;
  logic          RST;
  logic          wren;
  logic [PW-1:0] wrpage;
  logic [AW-1:0] wraddr;
  logic [DW-1:0] wrdata;
  logic          rden;
  logic [PW-1:0] rdpage;
  logic [AW-1:0] rdaddr;
  logic [DW-1:0] rddata;

  ram2port_paged #(
    .num_of_pages(NP),
    .pagesize    (PS),
    .data_width  (DW)
  ) dut (
    .VCLK  (VCLK),
    .RST   (RST),
    .wren  (wren),
    .wrpage(wrpage),
    .wraddr(wraddr),
    .wrdata(wrdata),
    .rden  (rden),
    .rdpage(rdpage),
    .rdaddr(rdaddr),
    .rddata(rddata)
  );

  initial VCLK = 1'b0;
  always #5 VCLK = ~VCLK;

  typedef struct {
    int            due;
    logic [DW-1:0] val;
  } rd_t;

  typedef struct {
    string         tag;
    int            cyc;
    logic [DW-1:0] val;
  } exp_t;

  // Reference model: memory as pages x words, reads in flight with due cycle.
  logic [DW-1:0] mm [NP][PS];
  rd_t           inflight [$];
  exp_t          exp_q [$];
  logic [DW-1:0] out_m;
  int            cyc;

  int n_checks;
  int n_fail;

  task automatic check(input string name, input logic [DW-1:0] got,
                       input logic [DW-1:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: rddata=%h expected=%h", name, got, want);
    end
  endtask

  // One clock edge: drive inputs, let the edge happen, advance the model.
  task automatic step(input logic rst, input logic we, input int wp, input int wa,
                      input int wd, input logic re, input int rp, input int ra,
                      input string tag);
    rd_t  r;
    exp_t e;
    RST    = rst;
    wren   = we;
    wrpage = PW'(wp);
    wraddr = AW'(wa);
    wrdata = DW'(wd);
    rden   = re;
    rdpage = PW'(rp);
    rdaddr = AW'(ra);
    @(posedge VCLK);
    if (rst) begin
      inflight.delete();
      out_m = '0;
    end else begin
      if (inflight.size() > 0 && inflight[0].due == cyc) begin
        r     = inflight.pop_front();
        out_m = r.val;
      end
      if (we && wp < NP && wa < PS) mm[wp][wa] = DW'(wd);
      if (re) begin
        r.due = cyc + 1;
        r.val = (rp < NP && ra < PS) ? mm[rp][ra] : '0;
        inflight.push_back(r);
      end
    end
    e.tag = tag;
    e.cyc = cyc;
    e.val = out_m;
    exp_q.push_back(e);
    cyc++;
    #1;
  endtask

  task automatic idle(input string tag);
    step(1'b0, 1'b0, 0, 0, 0, 1'b0, 0, 0, tag);
  endtask

  task automatic wr(input int p, input int a, input int d, input string tag);
    step(1'b0, 1'b1, p, a, d, 1'b0, 0, 0, tag);
  endtask

  task automatic rd(input int p, input int a, input string tag);
    step(1'b0, 1'b0, 0, 0, 0, 1'b1, p, a, tag);
  endtask

  // Monitor: compares every edge's predicted rddata half a cycle later.
  exp_t mon_e;
  always @(negedge VCLK) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check($sformatf("%s cyc%0d", mon_e.tag, mon_e.cyc), rddata, mon_e.val);
    end
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    cyc      = 0;
    out_m    = '0;
    for (int p = 0; p < NP; p++)
      for (int a = 0; a < PS; a++) mm[p][a] = '0;

    // Reset state
    repeat (2) step(1'b1, 1'b0, 0, 0, 0, 1'b0, 0, 0, "reset");
    idle("reset_idle");

    // Basic write/read, result holds afterwards
    wr(0, 5, 'h155555, "basic_wr");
    wr(3, 799, 'h0AAAAA, "basic_wr");
    rd(0, 5, "basic_rd");
    repeat (3) idle("basic_hold0");
    rd(3, 799, "basic_rd");
    repeat (3) idle("basic_hold1");

    // Page isolation, one word per cycle
    for (int p = 0; p < NP; p++) wr(p, 10, p + 1, "page_wr");
    for (int p = NP - 1; p >= 0; p--) rd(p, 10, "page_rd");
    repeat (3) idle("page_out");

    // Read-during-write returns old data, next read sees new data
    wr(1, 7, 'h11, "rdw_init");
    idle("rdw_idle");
    rd(1, 7, "rdw_rd_old");
    wr(1, 7, 'h22, "rdw_collide");
    rd(1, 7, "rdw_rd_new");
    repeat (2) idle("rdw_out");

    // Out of range: write to addr 800 aliases flat index of page 1 addr 0
    wr(0, 0, 'h01234, "oor_init");
    wr(1, 0, 'h05678, "oor_init");
    wr(0, 800, 'h1FFFFF, "oor_wr");
    wr(3, 1000, 'h1ABCDE, "oor_wr");
    rd(0, 0, "oor_rd_p0");
    rd(1, 0, "oor_rd_p1");
    rd(0, 800, "oor_rd_800");
    rd(3, 1023, "oor_rd_1023");
    repeat (3) idle("oor_out");

    // rden hold: address wiggles with rden low, output must not move
    wr(2, 3, 'h3F, "hold_wr");
    rd(2, 3, "hold_rd");
    idle("hold_lat");
    for (int i = 0; i < 5; i++)
      step(1'b0, 1'b0, 0, 0, 0, 1'b0, i, 5 + i, "hold_rden0");

    // Reset during back-to-back reads, with a write attempted under reset
    rd(0, 5, "rst_rd");
    rd(3, 799, "rst_rd");
    step(1'b1, 1'b1, 0, 5, 'h1FFFFF, 1'b1, 0, 10, "rst_pulse");
    idle("rst_after");
    rd(0, 5, "rst_reread");
    rd(3, 799, "rst_reread");
    repeat (3) idle("rst_out");

    // Randomised traffic focused on a small address set to force collisions
    for (int i = 0; i < 400; i++) begin
      int wa, ra;
      wa = ($urandom_range(0, 3) == 0) ? $urandom_range(790, 810) : $urandom_range(0, 15);
      ra = ($urandom_range(0, 3) == 0) ? $urandom_range(790, 810) : $urandom_range(0, 15);
      step(($urandom_range(0, 49) == 0),
           ($urandom_range(0, 1) == 1), $urandom_range(0, NP - 1), wa,
           $urandom_range(0, (1 << DW) - 1),
           ($urandom_range(0, 9) < 7), $urandom_range(0, NP - 1), ra, "random");
    end
    repeat (3) idle("drain");

    repeat (2) @(negedge VCLK);
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ram2port_paged.md
Name: ram2port_paged

Overview:
- Simple dual-port synchronous RAM, one clock; one write port, one read port.
- Storage is organised as num_of_pages pages of pagesize words, each data_width bits wide.
- Used as the line buffer of the line doubler: it writes incoming lines page by page and reads them back at twice the rate with a fixed 2-cycle latency.

Parameters:
- num_of_pages, 4, number of pages (lines) stored.
- pagesize, 800, words per page.
- data_width, 21, bits per word (3 colour channels of 7 bits).
- Derived, not overridable: PW = clog2(num_of_pages) page-index width; AW = clog2(pagesize) address width.

Ports:
- VCLK  in  1  single clock for both ports; all logic on the rising edge.
- RST  in  1  synchronous reset, active-high.
- wren  in  1  write enable.
- wrpage  in  PW  write page index.
- wraddr  in  AW  word address within the write page.
- wrdata  in  data_width  write data.
- rden  in  1  read enable.
- rdpage  in  PW  read page index.
- rdaddr  in  AW  word address within the read page.
- rddata  out  data_width  registered read data.

Behaviour:
- Flat word index = page*pagesize + addr. Total depth is num_of_pages*pagesize.
- Write:
  - On a rising edge with wren=1, RST=0, wrpage<num_of_pages and wraddr<pagesize, mem[index] <= wrdata.
  - Out-of-range writes are ignored.
- Read pipeline, stage 1:
  - On a rising edge with rden=1, latch the read index and a valid flag (valid=1 only if rdpage and rdaddr are both in range).
  - With rden=0, clear the stage-1 enable flag. The latched index is don't-care.
- Read pipeline, stage 2:
  - On the next edge, if the stage-1 enable flag is set: rddata <= mem[latched index] when valid, otherwise 0.
  - If the flag is clear, rddata holds its value.
- Latency: rden/rdaddr presented before edge N give rddata valid after edge N+1, i.e. 2 cycles. A fresh address every cycle gives one word per cycle.
- Write/read visibility:
  - A word written at edge N is returned by a read whose address was latched at edge N or later.
  - Read-during-write on the same index at the same edge (stage 2 reading while the write lands) returns the old data.
- Reset (RST=1 on an edge):
  - rddata <= 0, stage-1 enable <= 0, stage-1 index <= 0.
  - Writes are blocked.
  - Memory contents are not cleared; power-up contents are all zero via initialisation.
  - Reset mid-read kills any in-flight read: rddata stays 0 until a new read has completed its 2 cycles after reset release.
- rdpage/wrpage wrap-around and page sequencing are the caller's job; this block performs no modulo arithmetic.
- The memory array must infer block RAM. There is no reset on the array and no asynchronous read.

Decomposition:
- Shared package holds: the defaults BUF_NUM_OF_PAGES=4, BUF_DEPTH_PER_PAGE=800 and colour width 7, plus a clog2 helper if the toolchain lacks $clog2.
- No sub-module. The array plus two pipeline registers form a single module.

Test Plan:
- Basic write/read: write page 0 addr 5 = 0x155555, page 3 addr 799 = 0x0AAAAA. Read each with rden=1 for one cycle -> exact values appear on rddata 2 edges later and hold afterwards.
- Page isolation: write addr 10 in pages 0–3 with 0x1, 0x2, 0x3, 0x4. Read back pages 3, 2, 1, 0 on consecutive cycles -> rddata sequence 0x4, 0x3, 0x2, 0x1 from cycle 2, one per cycle.
- Read-during-write: with mem[1][7]=0x11, write 0x22 to page 1 addr 7 on the same edge stage 2 reads it -> 0x11. The next read -> 0x22.
- Out of range:
  - Write wraddr=800 -> no word changes; page 0 addr 0 and page 1 addr 0 keep their values.
  - Read wraddr=800 (pagesize=800) -> rddata=0 after 2 cycles.
- rden hold: issue a read yielding 0x3F, then rden=0 with rdaddr changing for 5 cycles -> rddata stays 0x3F.
- Reset: assert RST for 1 cycle during back-to-back reads -> rddata=0 next edge; a write with wren=1 during RST leaves memory unchanged; previously written data is still readable after RST deasserts.
